// File: rtl/expand_mpc_challenge_multi.sv
// rtl/expand_mpc_challenge_multi.sv - SDitH MPC challenge expander; optional EXPAND_MPC_CHAL_BYTE_SWAP_EN
module expand_mpc_challenge_multi #(
  parameter int SEED_WORDS      = 8,
  parameter int WORDS_PER_ENTRY = 3,
  parameter int ENTRIES         = 17,
  parameter int N_CHAN          = 2,
  localparam int SAW = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1,
  localparam int CHW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
  localparam int EAW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int EW  = WORDS_PER_ENTRY * 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  output logic           o_busy,
  output logic           o_done,
  input  logic [31:0]    i_h1,
  output logic [SAW-1:0] o_h1_addr,
  output logic           o_h1_rd,
  input  logic           i_rd,
  input  logic [CHW-1:0] i_rd_chan,
  input  logic [EAW-1:0] i_rd_addr,
  output logic [EW-1:0]  o_rd_data,
  output logic [31:0]    o_hash_data_in,
  input  logic [SAW-1:0] i_hash_addr,
  input  logic           i_hash_rd_en,
  input  logic [31:0]    i_hash_data_out,
  input  logic           i_hash_data_out_valid,
  output logic           o_hash_data_out_ready,
  output logic [31:0]    o_hash_input_length,
  output logic [31:0]    o_hash_output_length,
  output logic           o_hash_start,
  output logic           o_hash_force_done,
  input  logic           i_hash_force_done_ack
);

  localparam int WCW   = (WORDS_PER_ENTRY > 1) ? $clog2(WORDS_PER_ENTRY) : 1;
  localparam int DEPTH = N_CHAN * ENTRIES;
  localparam int BAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HSTART, S_SQUEEZE, S_FLUSH, S_DONE} state_t;
  state_t state, state_nx;

  logic [31:0]    seed_ram [SEED_WORDS];
  logic [EW-1:0]  buf_ram  [DEPTH];
  logic [SAW-1:0] wr_addr, seed_rd_addr;
  logic           wr_en;
  logic [WCW-1:0] wc;
  logic [EAW-1:0] ec;
  logic [CHW-1:0] cc;
  logic [EW-1:0]  asm_q, asm_nx;
  logic [31:0]    sq_word;
  logic [BAW-1:0] buf_wr_idx, buf_rd_idx;
  logic           beat, entry_done, last_beat, load_last, rd_ok;

  assign o_hash_input_length  = 32'(SEED_WORDS * 32);
  assign o_hash_output_length = 32'(N_CHAN * ENTRIES * WORDS_PER_ENTRY * 32);

`ifdef EXPAND_MPC_CHAL_BYTE_SWAP_EN
  assign sq_word = {i_hash_data_out[7:0], i_hash_data_out[15:8],
                    i_hash_data_out[23:16], i_hash_data_out[31:24]};
`else
  assign sq_word = i_hash_data_out;
`endif

  assign beat       = (state == S_SQUEEZE) && i_hash_data_out_valid;
  assign entry_done = beat && (wc == WCW'(WORDS_PER_ENTRY - 1));
  assign last_beat  = entry_done && (ec == EAW'(ENTRIES - 1)) && (cc == CHW'(N_CHAN - 1));
  assign load_last  = (state == S_LOAD) && (o_h1_addr == SAW'(SEED_WORDS - 1));
  // Earlier words drift toward the MSBs so the first word of an entry ends on top.
  assign asm_nx     = (asm_q << 32) | EW'(sq_word);
  assign buf_wr_idx = BAW'(cc) * BAW'(ENTRIES) + BAW'(ec);
  assign buf_rd_idx = BAW'(i_rd_chan) * BAW'(ENTRIES) + BAW'(i_rd_addr);
  assign rd_ok      = !o_busy && (int'(i_rd_chan) < N_CHAN) && (int'(i_rd_addr) < ENTRIES);
  assign seed_rd_addr = i_hash_rd_en ? i_hash_addr : wr_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx              = state;
    o_busy                = 1'b0;
    o_done                = 1'b0;
    o_hash_start          = 1'b0;
    o_hash_data_out_ready = 1'b0;
    o_hash_force_done     = 1'b0;
    case (state)
      S_IDLE:    if (i_start) state_nx = S_LOAD;
      S_LOAD:    begin o_busy = 1'b1; if (load_last) state_nx = S_HSTART; end
      S_HSTART:  begin o_busy = 1'b1; o_hash_start = 1'b1; state_nx = S_SQUEEZE; end
      S_SQUEEZE: begin
        o_busy = 1'b1;
        o_hash_data_out_ready = 1'b1;
        if (last_beat) state_nx = S_FLUSH;
      end
      S_FLUSH:   begin
        o_busy = 1'b1;
        o_hash_force_done = 1'b1;
        if (i_hash_force_done_ack) state_nx = S_DONE;
      end
      S_DONE:    begin o_done = 1'b1; state_nx = S_IDLE; end
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_h1_rd        <= 1'b0;
      o_h1_addr      <= '0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wc             <= '0;
      ec             <= '0;
      cc             <= '0;
      asm_q          <= '0;
      o_hash_data_in <= '0;
      o_rd_data      <= '0;
    end else begin
      // The seed word arrives one cycle after its read strobe.
      wr_en          <= o_h1_rd;
      wr_addr        <= o_h1_addr;
      o_hash_data_in <= seed_ram[seed_rd_addr];
      if (state == S_IDLE && i_start) begin
        o_h1_rd   <= 1'b1;
        o_h1_addr <= '0;
        wc        <= '0;
        ec        <= '0;
        cc        <= '0;
      end else if (state == S_LOAD) begin
        if (load_last) begin
          o_h1_rd   <= 1'b0;
          o_h1_addr <= '0;
        end else begin
          o_h1_addr <= o_h1_addr + 1'b1;
        end
      end
      if (beat) begin
        asm_q <= asm_nx;
        if (entry_done) begin
          wc <= '0;
          if (ec == EAW'(ENTRIES - 1)) begin
            ec <= '0;
            cc <= (cc == CHW'(N_CHAN - 1)) ? '0 : cc + 1'b1;
          end else begin
            ec <= ec + 1'b1;
          end
        end else begin
          wc <= wc + 1'b1;
        end
      end
      if (i_rd) o_rd_data <= rd_ok ? buf_ram[buf_rd_idx] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) seed_ram[wr_addr] <= i_h1;
    if (entry_done) buf_ram[buf_wr_idx] <= asm_nx;
  end

endmodule

// File: tb/tb_expand_mpc_challenge_multi.sv
// tb/tb_expand_mpc_challenge_multi.sv - randomized model-checked bench for expand_mpc_challenge_multi
module tb_expand_mpc_challenge_multi;
  localparam int SW = 8, W = 3, E = 17, N = 2, TOTAL = N * E * W, EW = W * 32;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_rst = 1'b1, i_start = 1'b0, i_rd = 1'b0;
  logic          i_hash_rd_en = 1'b0, i_hash_data_out_valid = 1'b0, i_hash_force_done_ack = 1'b0;
  logic [0:0]    i_rd_chan = '0;
  logic [4:0]    i_rd_addr = '0;
  logic [2:0]    i_hash_addr = '0;
  logic [31:0]   i_h1 = '0, i_hash_data_out = '0;
  logic [2:0]    o_h1_addr;
  logic [31:0]   o_hash_data_in, o_hash_input_length, o_hash_output_length;
  logic          o_busy, o_done, o_h1_rd, o_hash_data_out_ready, o_hash_start, o_hash_force_done;
  logic [EW-1:0] o_rd_data;

  expand_mpc_challenge_multi dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .i_h1(i_h1), .o_h1_addr(o_h1_addr), .o_h1_rd(o_h1_rd),
    .i_rd(i_rd), .i_rd_chan(i_rd_chan), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_hash_data_in(o_hash_data_in), .i_hash_addr(i_hash_addr), .i_hash_rd_en(i_hash_rd_en),
    .i_hash_data_out(i_hash_data_out), .i_hash_data_out_valid(i_hash_data_out_valid),
    .o_hash_data_out_ready(o_hash_data_out_ready), .o_hash_input_length(o_hash_input_length),
    .o_hash_output_length(o_hash_output_length), .o_hash_start(o_hash_start),
    .o_hash_force_done(o_hash_force_done), .i_hash_force_done_ack(i_hash_force_done_ack)
  );

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;
  logic [31:0] seed [SW];
  logic [31:0] base = '0;
  int vmode = 0, ack_delay = 1, vcnt = 0;
  // Reference model: run phase as a cycle index since start plus a beat count.
  bit m_busy = 0, m_done = 0, m_buf_ok = 0, m_rd_chk = 0, m_hin_chk = 0;
  int m_t = 0, m_beats = 0, m_fd = 0;
  logic [EW-1:0] m_rd = '0;
  logic [31:0] m_hin = '0;
  int dut_beats = 0, dut_fd = 0;
  bit h1_rd_s = 0;
  logic [2:0] h1_addr_s = '0;

  function automatic logic [31:0] stored(int k);
    logic [31:0] w;
    w = base + 32'(k);
`ifdef EXPAND_MPC_CHAL_BYTE_SWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  function automatic logic [EW-1:0] entry(int ch, int e);
    logic [EW-1:0] r;
    r = '0;
    for (int j = 0; j < W; j++) r = {r[EW-33:0], stored((ch * E + e) * W + j)};
    return r;
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic update_model();
    if (i_rst) begin
      m_busy = 0; m_done = 0; m_t = 0; m_beats = 0; m_fd = 0; m_buf_ok = 0;
      m_rd = '0; m_rd_chk = 1; m_hin_chk = 0;
      return;
    end
    if (i_rd) begin
      m_rd_chk = 1;
      if (m_busy || int'(i_rd_chan) >= N || int'(i_rd_addr) >= E) m_rd = '0;
      else if (m_buf_ok) m_rd = entry(int'(i_rd_chan), int'(i_rd_addr));
      else m_rd_chk = 0;
    end
    m_hin_chk = i_hash_rd_en;
    if (i_hash_rd_en) m_hin = seed[i_hash_addr];
    if (m_done) m_done = 0;
    else if (!m_busy) begin
      if (i_start) begin m_busy = 1; m_t = 0; m_beats = 0; m_fd = 0; m_buf_ok = 0; end
    end else if (m_beats < TOTAL) begin
      if (m_t > SW + 1 && i_hash_data_out_valid) begin
        m_beats++;
        if (m_beats == TOTAL) m_buf_ok = 1;
      end
    end else begin
      m_fd++;
      if (i_hash_force_done_ack) begin m_busy = 0; m_done = 1; end
    end
    if (m_busy) m_t++;
  endtask

  task automatic drive_next();
    bit rdy_next;
    rdy_next = m_busy && m_t > SW + 1 && m_beats < TOTAL;
    vcnt++;
    case (vmode)
      0:       i_hash_data_out_valid = 1'b1;
      1:       i_hash_data_out_valid = (vcnt % 3 == 0);
      default: i_hash_data_out_valid = 1'($urandom % 2);
    endcase
    i_hash_data_out       = base + 32'(m_beats);
    i_hash_force_done_ack = m_busy && m_beats == TOTAL && (m_fd + 1 >= ack_delay);
    i_hash_rd_en          = rdy_next && 1'($urandom % 2);
    i_hash_addr           = 3'($urandom);
    i_h1                  = h1_rd_s ? seed[h1_addr_s] : $urandom;
  endtask

  task automatic step();
    h1_rd_s   = o_h1_rd;
    h1_addr_s = o_h1_addr;
    @(posedge i_clk);
    update_model();
    #1;
    drive_next();
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("busy", EW'(o_busy), EW'(m_busy));
      chk("done", EW'(o_done), EW'(m_done));
      chk("h1_rd", EW'(o_h1_rd), EW'(m_busy && m_t >= 1 && m_t <= SW));
      if (m_busy && m_t <= SW) chk("h1_addr", EW'(o_h1_addr), EW'(m_t - 1));
      chk("hash_start", EW'(o_hash_start), EW'(m_busy && m_t == SW + 1));
      chk("ready", EW'(o_hash_data_out_ready), EW'(m_busy && m_t > SW + 1 && m_beats < TOTAL));
      chk("force_done", EW'(o_hash_force_done), EW'(m_busy && m_beats == TOTAL));
      if (m_rd_chk) chk("rd_data", o_rd_data, m_rd);
      if (m_hin_chk) chk("hash_data_in", EW'(o_hash_data_in), EW'(m_hin));
      if (o_hash_data_out_ready && i_hash_data_out_valid) dut_beats++;
      if (o_hash_force_done) dut_fd++;
    end
  end

  task automatic run(input logic [31:0] b, input int vm, input int ad, input bit inject);
    int budget;
    bit injected;
    budget = 4000; injected = 0;
    base = b; vmode = vm; ack_delay = ad; vcnt = 0; dut_beats = 0; dut_fd = 0;
    i_start = 1; step(); i_start = 0;
    while (!m_done && budget > 0) begin
      if (inject && !injected && m_beats == 40) begin
        injected = 1;
        i_start = 1; i_rd = 1; i_rd_chan = '0; i_rd_addr = '0;
        step();
        i_start = 0; i_rd = 0;
        chk("rd_while_busy", o_rd_data, '0);
      end else step();
      budget--;
    end
    if (budget == 0) begin
      tests++; fails++;
      $display("FAIL run_timeout: got no done, required done within 4000 cycles");
    end
    step();
  endtask

  task automatic rd(input int ch, input int a);
    i_rd = 1; i_rd_chan = 1'(ch); i_rd_addr = 5'(a);
    step();
    i_rd = 0;
  endtask

  task automatic lit_reads();
`ifdef EXPAND_MPC_CHAL_BYTE_SWAP_EN
    rd(0, 0);  chk("swap_ch0_a0_hi", EW'(o_rd_data[EW-1:EW-32]), EW'(32'h44332211));
`else
    rd(0, 0);  chk("ch0_a0", o_rd_data, {32'd0, 32'd1, 32'd2});
    rd(0, 16); chk("ch0_a16", o_rd_data, {32'd48, 32'd49, 32'd50});
    rd(1, 0);  chk("ch1_a0", o_rd_data, {32'd51, 32'd52, 32'd53});
    rd(1, 16); chk("ch1_a16", o_rd_data, {32'd99, 32'd100, 32'd101});
`endif
  endtask

  task automatic read_all();
    for (int c = 0; c < N; c++)
      for (int e = 0; e < E; e++) rd(c, e);
    step();
  endtask

  initial begin
    logic [31:0] b0;
    int budget;
    for (int i = 0; i < SW; i++) seed[i] = 32'(i + 1);
`ifdef EXPAND_MPC_CHAL_BYTE_SWAP_EN
    b0 = 32'h11223344;
`else
    b0 = 32'h0;
`endif
    i_rst = 1; step(); chk_en = 1; step(); i_rst = 0; step();
    chk("rst_busy", EW'(o_busy), '0);
    chk("rst_ready", EW'(o_hash_data_out_ready), '0);
    chk("in_len", EW'(o_hash_input_length), EW'(32'd256));
    chk("out_len", EW'(o_hash_output_length), EW'(32'd3264));

    run(b0, 0, 1, 0);
    chk("beats_run1", EW'(dut_beats), EW'(102));
    lit_reads();

    for (int i = 0; i < SW; i++) seed[i] = $urandom;
    run(b0, 1, 2, 0);
    chk("beats_stall", EW'(dut_beats), EW'(102));
    lit_reads();

    run($urandom, 2, 5, 1);
    chk("fd_cycles", EW'(dut_fd), EW'(5));
    read_all();

    for (int i = 0; i < SW; i++) seed[i] = $urandom;
    base = $urandom; vmode = 2; vcnt = 0;
    i_start = 1; step(); i_start = 0;
    budget = 2000;
    while (m_beats < 50 && budget > 0) begin step(); budget--; end
    i_rst = 1; step(); i_rst = 0;
    chk("mid_rst_busy", EW'(o_busy), '0);
    chk("mid_rst_done", EW'(o_done), '0);
    chk("mid_rst_h1_rd", EW'(o_h1_rd), '0);
    chk("mid_rst_h1_addr", EW'(o_h1_addr), '0);
    chk("mid_rst_hstart", EW'(o_hash_start), '0);
    chk("mid_rst_fd", EW'(o_hash_force_done), '0);
    chk("mid_rst_ready", EW'(o_hash_data_out_ready), '0);
    chk("mid_rst_rd_data", o_rd_data, '0);
    step();
    run($urandom, 2, 1, 0);
    chk("beats_after_rst", EW'(dut_beats), EW'(102));
    read_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/expand_mpc_challenge_multi.md
Name: expand_mpc_challenge_multi

Overview:
Parametrised successor challenge expander for the SDitH signer. Latches the H1 seed, drives the shared SHAKE core, and splits the squeezed stream into N_CHAN challenge buffers (r, eps, and further channels) of ENTRIES x WORDS_PER_ENTRY words. Word count, entry count and channel count are generic. Adds hash back-pressure tolerance, a busy flag, force-done acknowledge, and a single muxed read port with fixed latency.

Parameters:
SEED_WORDS, 8, 32-bit words of seed H1 (2*LAMBDA/32)
WORDS_PER_ENTRY, 3, 32-bit words packed per entry (T); >=1
ENTRIES, 17, entries per channel (TAU*D_SPLIT)
N_CHAN, 2, number of challenge buffers filled in order 0..N_CHAN-1; >=1

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_start  in  1  start pulse; ignored while o_busy=1
o_busy  out  1  high from the cycle after accepted i_start until o_done
o_done  out  1  one-cycle completion pulse
i_h1  in  32  seed word; valid one cycle after o_h1_rd/o_h1_addr
o_h1_addr  out  clog2(SEED_WORDS)  seed read address
o_h1_rd  out  1  seed read strobe
i_rd  in  1  buffer read strobe
i_rd_chan  in  clog2(N_CHAN) (min 1)  channel select
i_rd_addr  in  clog2(ENTRIES)  entry address
o_rd_data  out  WORDS_PER_ENTRY*32  entry; valid one cycle after i_rd
o_hash_data_in  out  32  seed word to hash core
i_hash_addr  in  clog2(SEED_WORDS)  hash seed read address
i_hash_rd_en  in  1  hash seed read enable
i_hash_data_out  in  32  squeezed word
i_hash_data_out_valid  in  1  squeezed word valid
o_hash_data_out_ready  out  1  squeeze ready
o_hash_input_length  out  32  constant SEED_WORDS*32
o_hash_output_length  out  32  constant N_CHAN*ENTRIES*WORDS_PER_ENTRY*32
o_hash_start  out  1  one-cycle hash start pulse
o_hash_force_done  out  1  hash terminate request, held until ack
i_hash_force_done_ack  in  1  hash terminate acknowledge

Behaviour:
- Clock i_clk; reset i_rst, synchronous, active-high.
- Reset: state IDLE; o_busy, o_done, o_h1_rd, o_hash_start, o_hash_force_done, o_hash_data_out_ready = 0; o_h1_addr = 0; all counters = 0. Buffer and seed RAM contents are retained but undefined after a mid-run reset.
- States: IDLE -> LOAD -> HSTART -> SQUEEZE -> FLUSH -> DONE -> IDLE.
- IDLE: on i_start, go to LOAD and issue o_h1_rd=1 with o_h1_addr=0 in the same cycle.
- LOAD: o_h1_rd=1; o_h1_addr steps 0..SEED_WORDS-1, one per cycle. Seed RAM writes i_h1 at the registered address/strobe one cycle later. After address SEED_WORDS-1, go to HSTART.
- Seed RAM read address is i_hash_addr when i_hash_rd_en=1, else the internal write address. Read latency is 1 cycle.
- HSTART: one cycle. o_hash_start=1, which also covers the last seed write. Then go to SQUEEZE.
- SQUEEZE: o_hash_data_out_ready=1 throughout.
  - A beat is valid & ready. Stalls (valid=0) of any length are tolerated; no word is lost or duplicated.
  - Each beat shifts into an assembly register: first word of the entry ends in bits [W*32-1:(W-1)*32], last word in [31:0].
  - Counters: word counter wc 0..WORDS_PER_ENTRY-1, entry counter ec 0..ENTRIES-1, channel counter cc 0..N_CHAN-1.
  - On the beat with wc=WORDS_PER_ENTRY-1: the assembled entry (including this beat) is written to buffer[cc][ec] on the next edge, and wc wraps to 0.
  - ec wraps at ENTRIES-1 and increments cc.
  - On the beat completing cc=N_CHAN-1, ec=ENTRIES-1: ready drops the next cycle and state goes to FLUSH.
  - Beats after the last are not accepted.
- FLUSH: o_hash_force_done=1 until i_hash_force_done_ack is sampled high; ack in the first FLUSH cycle is legal. Then go to DONE.
- DONE: o_done=1 for one cycle, o_busy drops in the same cycle, go to IDLE.
- Read port:
  - i_rd is honoured only while o_busy=0. o_rd_data = buffer[i_rd_chan][i_rd_addr] on the next cycle.
  - i_rd while busy, or i_rd_chan >= N_CHAN, returns 0 next cycle.
  - o_rd_data holds its value when i_rd=0.
- i_start while busy is ignored. A new start after DONE overwrites all buffers.

Optional Feature:
EXPAND_MPC_CHAL_BYTE_SWAP_EN: when defined, each squeezed word is byte-reversed ({b0,b1,b2,b3}) before entering the assembly register, giving little-endian SHAKE output. When undefined, words are stored as received. Counts, timing and handshakes are identical in both builds.

Test Plan:
- Defaults, seed words 0x00000001..0x00000008, hash returns an incrementing word k from 0 every cycle -> o_hash_input_length=256, o_hash_output_length=3264; after done, read ch0 addr0 = {0,1,2}, ch0 addr16 = {48,49,50}, ch1 addr0 = {51,52,53}, ch1 addr16 = {99,100,101}.
- Same run with valid toggling 1-0-0-1 -> identical buffer contents; exactly 102 beats accepted.
- Ack delayed 5 cycles after force_done -> force_done held 5 cycles, then one-cycle o_done, o_busy=0.
- i_start and i_rd pulsed mid-SQUEEZE -> start ignored, o_rd_data=0 next cycle.
- i_rst asserted mid-SQUEEZE, then a fresh run -> all outputs 0 after reset; second run produces the correct full buffers.
- BYTE_SWAP build, hash word 0x11223344 first -> ch0 addr0 upper word = 0x44332211.
